// File: rtl/ram_ws_pkg.sv
// Shared types and constants for the wait-state data memory.
// Holds the FSM encoding, the wait-counter sizing and the byte-lane helper.
package ram_ws_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WAIT_MAX   = 15;
    localparam int CNT_W      = 4;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W       = DATA_W_DEF / 8;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_ws_array.sv
// Storage array with a byte-masked write port and a registered read port.
// A read and a write on the same edge return the old word.
module ram_ws_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [NB-1:0]     be,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (re) begin
            q_reg <= mem[raddr];
        end
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/ram_ws.sv
// Data memory with programmable wait states, ready/busy handshake and error pulse.
// The array is read on the edge entering DONE and written on the edge leaving it.
module ram_ws
    import ram_ws_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     nce,
    input  logic                     MemWrite,
    input  logic                     MemRead,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ready,
    output logic                     busy,
    output logic                     err
);

    localparam int NB = be_width(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [NB-1:0]      be_reg;
    logic               wr_reg;
    logic               oor_reg;
    logic               err_reg;
    logic [DATA_W-1:0]  rdata_reg;

    logic               accept;
    logic               in_range;
    logic               done;
    logic               arr_re;
    logic               arr_we;
    logic [ADDR_W-1:0]  arr_raddr;
    logic [DATA_W-1:0]  arr_q;
    logic [DATA_W-1:0]  rdata_done;

    assign accept   = !nce && (MemRead || MemWrite);
    assign in_range = {1'b0, address} < DEPTH_L;
    assign done     = (state_reg == ST_DONE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    cnt_next   = CNT_W'(WAIT_STATES);
                    state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == ST_IDLE && accept) begin
                addr_reg  <= address;
                wdata_reg <= wdata;
                be_reg    <= be;
                wr_reg    <= MemWrite;
                oor_reg   <= !in_range;
                err_reg   <= !in_range || (MemRead && MemWrite);
            end
            if (done) begin
                rdata_reg <= rdata_done;
            end
        end
    end

    // In IDLE the raw address is presented so a zero-wait access has data in DONE.
    assign arr_raddr = (state_reg == ST_IDLE) ? address  : addr_reg;
    assign arr_re    = (state_reg == ST_IDLE) ? in_range : !oor_reg;
    assign arr_we    = done && wr_reg && !oor_reg && !reset;

    ram_ws_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NB     (NB)
    ) u_array (
        .clk   (clk),
        .re    (arr_re),
        .raddr (arr_raddr),
        .q     (arr_q),
        .we    (arr_we),
        .waddr (addr_reg),
        .be    (be_reg),
        .wdata (wdata_reg)
    );

    assign rdata_done = oor_reg ? '0 : arr_q;
    assign rdata      = done ? rdata_done : rdata_reg;
    assign ready      = done;
    assign busy       = (state_reg != ST_IDLE);
    assign err        = done && err_reg;

endmodule

// File: tb/tb_ram_ws.sv
// Directed bench for ram_ws: one zero-wait instance (DEPTH=200) and one
// three-wait-state instance (DEPTH=256), sharing the request inputs.
module tb_ram_ws;

    logic        clk = 1'b0;
    logic        reset;
    logic        nce0, nce3;
    logic        mem_write, mem_read;
    logic [3:0]  be;
    logic [7:0]  address;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata3;
    logic        ready0, ready3, busy0, busy3, err0, err3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_ws #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .nce(nce0), .MemWrite(mem_write), .MemRead(mem_read),
        .be(be), .address(address), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
    );

    ram_ws #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) u3 (
        .clk(clk), .reset(reset), .nce(nce3), .MemWrite(mem_write), .MemRead(mem_read),
        .be(be), .address(address), .wdata(wdata),
        .rdata(rdata3), .ready(ready3), .busy(busy3), .err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic release_bus();
        nce0 = 1'b1; nce3 = 1'b1; mem_write = 1'b0; mem_read = 1'b0;
    endtask

    // One access on the selected instance; returns data, err, latency and busy cycles.
    task automatic access(input int sel, input bit wr, input bit rd, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output logic [31:0] q, output logic e, output int lat, output int bcyc);
        logic rdy, bsy;
        q = '0; e = 1'b0; lat = -1; bcyc = 0;
        address = a; wdata = d; be = b; mem_write = wr; mem_read = rd;
        if (sel == 0) nce0 = 1'b0; else nce3 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) release_bus();
            rdy = (sel == 0) ? ready0 : ready3;
            bsy = (sel == 0) ? busy0 : busy3;
            if (bsy) bcyc++;
            if (rdy) begin
                q = (sel == 0) ? rdata0 : rdata3;
                e = (sel == 0) ? err0 : err3;
                lat = k;
                break;
            end
        end
        chk("ready_seen", 32'(lat > 0), 32'd1);
        @(posedge clk); #1;
        chk("ready_pulse", 32'((sel == 0) ? ready0 : ready3), 32'd0);
        chk("idle_busy", 32'((sel == 0) ? busy0 : busy3), 32'd0);
        $display("access u%0d wr=%0d rd=%0d addr=%h wdata=%h be=%h -> rdata=%h err=%0d lat=%0d",
                 (sel == 0) ? 0 : 3, wr, rd, a, d, b, q, e, lat);
    endtask

    initial begin
        logic [31:0] q;
        logic        e;
        int          lat, bc, readies, rlat;
        logic [31:0] rq;

        reset = 1'b1;
        be = '0; address = '0; wdata = '0;
        release_bus();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata0, 32'h0);
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        reset = 1'b0;

        // Zero-wait write/read
        access(0, 1, 0, 8'h05, 32'hDEADBEEF, 4'hF, q, e, lat, bc);
        chk("w5_lat", 32'(lat), 32'd1);
        chk("w5_err", 32'(e), 32'd0);
        access(0, 0, 1, 8'h05, 32'h0, 4'h0, q, e, lat, bc);
        chk("r5_lat", 32'(lat), 32'd1);
        chk("r5_busy", 32'(bc), 32'd1);
        chk("r5_data", q, 32'hDEADBEEF);
        chk("r5_err", 32'(e), 32'd0);
        chk("r5_hold", rdata0, 32'hDEADBEEF);

        // be=0 completes without writing
        access(0, 1, 0, 8'h05, 32'h00000000, 4'h0, q, e, lat, bc);
        chk("be0_lat", 32'(lat), 32'd1);
        access(0, 0, 1, 8'h05, 32'h0, 4'h0, q, e, lat, bc);
        chk("be0_data", q, 32'hDEADBEEF);

        // Byte enables
        access(0, 1, 0, 8'h03, 32'h11223344, 4'hF, q, e, lat, bc);
        access(0, 1, 0, 8'h03, 32'hAABBCCDD, 4'b0101, q, e, lat, bc);
        access(0, 0, 1, 8'h03, 32'h0, 4'h0, q, e, lat, bc);
        chk("be_merge", q, 32'h11BB33DD);

        // Out of range on DEPTH=200
        access(0, 1, 0, 8'd10, 32'h0A0A0A0A, 4'hF, q, e, lat, bc);
        access(0, 0, 1, 8'd210, 32'h0, 4'h0, q, e, lat, bc);
        chk("oor_rd_err", 32'(e), 32'd1);
        chk("oor_rd_data", q, 32'h0);
        chk("oor_rd_lat", 32'(lat), 32'd1);
        access(0, 1, 0, 8'd210, 32'hFFFFFFFF, 4'hF, q, e, lat, bc);
        chk("oor_wr_err", 32'(e), 32'd1);
        access(0, 0, 1, 8'd10, 32'h0, 4'h0, q, e, lat, bc);
        chk("no_alias", q, 32'h0A0A0A0A);
        chk("no_alias_err", 32'(e), 32'd0);

        // Read and write together: read-old, write performed
        access(0, 1, 0, 8'd7, 32'h1, 4'hF, q, e, lat, bc);
        access(0, 1, 1, 8'd7, 32'h2, 4'hF, q, e, lat, bc);
        chk("rw_old", q, 32'h1);
        chk("rw_err", 32'(e), 32'd1);
        access(0, 0, 1, 8'd7, 32'h0, 4'h0, q, e, lat, bc);
        chk("rw_new", q, 32'h2);

        // Three wait states
        access(3, 1, 0, 8'h09, 32'h0, 4'hF, q, e, lat, bc);
        chk("ws_w_lat", 32'(lat), 32'd4);
        access(3, 1, 0, 8'h11, 32'h12345678, 4'hF, q, e, lat, bc);
        access(3, 0, 1, 8'h11, 32'h0, 4'h0, q, e, lat, bc);
        chk("ws_r_lat", 32'(lat), 32'd4);
        chk("ws_r_busy", 32'(bc), 32'd4);
        chk("ws_r_data", q, 32'h12345678);

        // Request issued while busy is ignored
        address = 8'h11; mem_read = 1'b1; mem_write = 1'b0; be = 4'h0; nce3 = 1'b0;
        readies = 0; rlat = -1; rq = '0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                mem_read = 1'b0; mem_write = 1'b1; wdata = 32'hFFFFFFFF; be = 4'hF;
            end
            if (k == 3) release_bus();
            if (ready3) begin
                readies++;
                if (rlat < 0) begin rlat = k; rq = rdata3; end
            end
        end
        $display("access u3 busy-overlap read addr=11 -> readies=%0d lat=%0d rdata=%h", readies, rlat, rq);
        chk("ovl_readies", 32'(readies), 32'd1);
        chk("ovl_lat", 32'(rlat), 32'd4);
        chk("ovl_data", rq, 32'h12345678);
        access(3, 0, 1, 8'h11, 32'h0, 4'h0, q, e, lat, bc);
        chk("ovl_nowrite", q, 32'h12345678);

        // Reset during WAIT aborts the write
        address = 8'h09; wdata = 32'hCAFE0000; be = 4'hF; mem_write = 1'b1; nce3 = 1'b0;
        @(posedge clk); #1;
        release_bus();
        @(posedge clk); #1;
        chk("abort_busy_mid", 32'(busy3), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy3), 32'd0);
        readies = 0;
        for (int k = 0; k < 6; k++) begin
            if (ready3) readies++;
            @(posedge clk); #1;
        end
        $display("access u3 aborted write addr=09 -> readies=%0d", readies);
        chk("abort_ready", 32'(readies), 32'd0);
        access(3, 0, 1, 8'h09, 32'h0, 4'h0, q, e, lat, bc);
        chk("abort_data", q, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_ws.md
Name: ram_ws

Overview:
- Parametrised synchronous data memory for the multicycle MIPS datapath; successor to the fixed 256x32 RAM.
- Adds configurable depth and width, per-byte write enables and programmable wait states.
- Adds a registered read path with a ready/busy handshake and an error flag for out-of-range or conflicting accesses.
- Sits between the control unit/datapath and the memory bus. The control FSM stalls on busy and samples rdata on ready.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 8, word-address width.
- DEPTH, 256, number of words implemented; must satisfy DEPTH <= 2**ADDR_W.
- WAIT_STATES, 0, extra cycles inserted before completion (0..15).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- nce  in  1  chip enable, active low.
- MemWrite  in  1  write request.
- MemRead  in  1  read request.
- be  in  DATA_W/8  byte write enables; bit i covers wdata[8i+7:8i].
- address  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  registered read data; valid when ready=1.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  access in progress; new requests ignored.
- err  out  1  one-cycle pulse together with ready on an errored access.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: rdata=0, ready=0, busy=0, err=0, FSM in IDLE, wait counter 0. Memory contents are not reset.
- Outputs are always driven. There is no tri-state: rdata holds its last value between accesses.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - A request is accepted when nce=0 and (MemRead|MemWrite)=1.
  - On accept, latch address, wdata, be, the op and the error condition, and load cnt=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, otherwise DONE.
  - busy=1 from the cycle after accept until the DONE cycle inclusive.
- WAIT: decrement cnt each cycle; go to DONE when cnt reaches 1.
- DONE:
  - Commit the access.
  - Assert ready=1 and err=error_latched for exactly one cycle.
  - Return to IDLE.
- Latency: ready asserts WAIT_STATES+1 cycles after the accept edge. Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- Write commit, in DONE only:
  - mem[addr][8i+:8] <= wdata_l[8i+:8] for every i with be_l[i]=1.
  - be=0 performs no write but still completes with ready.
- Read: in DONE, rdata <= mem[addr_l], with the read occurring before that cycle's write.
- Input changes while busy are ignored. Only latched values are used.
- Error conditions, both complete normally with err=1:
  - address >= DEPTH: writes are suppressed and rdata is loaded with 0.
  - MemRead=1 and MemWrite=1 together: the write is performed and rdata is loaded with the pre-write word (read-old).
- nce=1 or no request in IDLE: nothing happens and outputs hold.
- Reset mid-access (WAIT or DONE):
  - The FSM goes to IDLE and the access is aborted.
  - No write is committed unless the DONE edge has already passed.
  - ready is not asserted for the aborted access.
- Wrap-around: the address does not wrap. Out-of-range addresses are errors, never aliased.

Decomposition:
- Shared package ram_ws_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_WAIT=2'd1, ST_DONE=2'd2;
  - BE_W = DATA_W/8;
  - maximum WAIT_STATES constant (15) and the counter width (4).
- One sub-module is natural: ram_ws_array, the storage array plus byte-masked write and synchronous read-old port.
- The FSM, wait counter and error logic stay in ram_ws.

Test Plan:
- Reset, then write address 8'h05 with data 32'hDEADBEEF and be=4'hF (WAIT_STATES=0), then read 8'h05 -> ready one cycle after each accept; rdata=32'hDEADBEEF; err=0.
- Byte enables: write 32'h11223344 to address 3, then write 32'hAABBCCDD with be=4'b0101 -> a subsequent read returns 32'h11BB33DD.
- WAIT_STATES=3 read:
  - ready exactly 4 cycles after accept; busy high for 4 cycles.
  - A second request issued while busy is ignored, with no extra ready.
- DEPTH=200: read address 8'd210 -> ready=1, err=1, rdata=0. A write to 8'd210 leaves address 210 mod 200 = 10 unchanged.
- MemRead=MemWrite=1 at address 7 holding 32'h1, wdata=32'h2 -> rdata=32'h1 and err=1; a later read of address 7 returns 32'h2.
- WAIT_STATES=3: assert reset during WAIT of a write of 32'hCAFE0000 to address 9 holding 32'h0 -> no ready; busy=0 after reset; a read of address 9 returns 32'h0.
